alu_op_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_op_sequencer_if.sv | 26 ++
 rtl/alu_op_sequencer.sv | 126 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU front-end: ALU control codes, request opcodes
// and the sequencer state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_MUL  = 2'd2;
  localparam state_t ST_RESP = 2'd3;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response channel between the execute-stage requester (master)
// and the ALU operation sequencer (slave).
interface alu_op_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Front-end controller for the shared ALU: single-pass ADD/SUB/AND/OR and an
// iterative shift-add MUL that reuses the ALU add path.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_op_sequencer_if.slave   bus,
  output logic [2:0]          alu_control,
  output logic [WIDTH-1:0]    alu_src1,
  output logic [WIDTH-1:0]    alu_src2,
  input  logic [WIDTH-1:0]    alu_ans,
  input  logic                alu_zero
);

  localparam int IW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [2:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [IW-1:0]    iter;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_zero_q;
  logic             rsp_err_q;

  logic             op_legal;
  logic [WIDTH-1:0] acc_next;
  logic             mul_done;

  assign op_legal = ~op[2];
  assign acc_next = op_b[0] ? alu_ans : acc;
  // A zero multiplier on entry also exits here after one pass with acc still 0.
  assign mul_done = (iter == IW'(WIDTH - 1)) ||
                    (EARLY_EXIT && ((op_b >> 1) == '0));

  assign bus.req_ready  = rst_n && (state == ST_IDLE);
  assign bus.rsp_valid  = (state == ST_RESP);
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;

  // ALU sits at add/0/0 except while an operation is actually using it.
  always_comb begin
    alu_control = ALU_ADD;
    alu_src1    = '0;
    alu_src2    = '0;
    case (state)
      ST_EXEC: begin
        if (op_legal) begin
          alu_control = op;
          alu_src1    = op_a;
          alu_src2    = op_b;
        end
      end
      ST_MUL: begin
        alu_control = ALU_ADD;
        alu_src1    = acc;
        alu_src2    = op_a;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      op           <= '0;
      op_a         <= '0;
      op_b         <= '0;
      acc          <= '0;
      iter         <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            op    <= bus.req_op;
            op_a  <= bus.req_a;
            op_b  <= bus.req_b;
            acc   <= '0;
            iter  <= '0;
            state <= (bus.req_op == OP_MUL) ? ST_MUL : ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (op_legal) begin
            rsp_result_q <= alu_ans;
            rsp_zero_q   <= alu_zero;
            rsp_err_q    <= 1'b0;
          end else begin
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b1;
          end
          state <= ST_RESP;
        end
        ST_MUL: begin
          acc  <= acc_next;
          op_a <= op_a << 1;
          op_b <= op_b >> 1;
          iter <= iter + 1'b1;
          if (mul_done) begin
            rsp_result_q <= acc_next;
            rsp_zero_q   <= (acc_next == '0);
            rsp_err_q    <= 1'b0;
            state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: behavioural ALU, scoreboard of
// expected responses and a monitor that checks value and latency of each one.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             err;
    int               lat;
    int               acc_cycle;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] alu_src1;
  logic [WIDTH-1:0] alu_src2;
  logic [WIDTH-1:0] alu_ans;
  logic             alu_zero;

  int   total;
  int   bad;
  int   cycle_count;
  bit   in_rsp;
  exp_t sb[$];

  alu_op_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_op_sequencer #(.WIDTH(WIDTH), .EARLY_EXIT(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .alu_control (alu_control),
    .alu_src1    (alu_src1),
    .alu_src2    (alu_src2),
    .alu_ans     (alu_ans),
    .alu_zero    (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_count <= cycle_count + 1;

  // Behavioural ALU; it raises the zero flag only for SUB.
  always_comb begin
    alu_ans = '0;
    case (alu_control)
      ALU_ADD: alu_ans = alu_src1 + alu_src2;
      ALU_SUB: alu_ans = alu_src1 - alu_src2;
      ALU_AND: alu_ans = alu_src1 & alu_src2;
      ALU_OR:  alu_ans = alu_src1 | alu_src2;
      default: alu_ans = '0;
    endcase
    alu_zero = (alu_control == ALU_SUB) && (alu_ans == '0);
  end

  // Monitor: on the first cycle of each response, pop and compare.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (!rst_n) begin
      in_rsp = 1'b0;
    end else if (bus.rsp_valid && !in_rsp) begin
      in_rsp = 1'b1;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_rsp: got result=%h err=%b, want no response",
                 bus.rsp_result, bus.rsp_err);
      end else begin
        e   = sb.pop_front();
        lat = cycle_count - e.acc_cycle;
        total += 4;
        if (bus.rsp_result !== e.result) begin
          bad++;
          $display("[TB] FAIL rsp_result: got %h want %h", bus.rsp_result, e.result);
        end
        if (bus.rsp_zero !== e.zero) begin
          bad++;
          $display("[TB] FAIL rsp_zero: got %b want %b", bus.rsp_zero, e.zero);
        end
        if (bus.rsp_err !== e.err) begin
          bad++;
          $display("[TB] FAIL rsp_err: got %b want %b", bus.rsp_err, e.err);
        end
        if (lat != e.lat) begin
          bad++;
          $display("[TB] FAIL latency: got %0d want %0d", lat, e.lat);
        end
      end
    end else if (!bus.rsp_valid) begin
      in_rsp = 1'b0;
    end
  end

  function automatic exp_t model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    exp_t e;
    int   n;
    e.err = 1'b0;
    e.zero = 1'b0;
    e.lat = 1;
    e.acc_cycle = 0;
    case (op)
      OP_ADD: e.result = a + b;
      OP_SUB: begin e.result = a - b; e.zero = (e.result == '0); end
      OP_AND: e.result = a & b;
      OP_OR:  e.result = a | b;
      OP_MUL: begin
        e.result = a * b;
        e.zero = (e.result == '0);
        n = 0;
        for (int i = 0; i < WIDTH; i++) if (b[i]) n = i + 1;
        e.lat = (n == 0) ? 1 : n;
      end
      default: begin e.result = '0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  // Drive one request until accepted; optionally queue the expected response.
  task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input bit expect_rsp);
    bit   rdy;
    bit   done;
    exp_t e;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      rdy = bus.req_ready;
      @(posedge clk);
      #1;
      done = rdy;
    end
    bus.req_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got no accept, want accept within 200 cycles");
    end else if (expect_rsp) begin
      e = model(op, a, b);
      e.acc_cycle = cycle_count;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.rsp_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: got %0d pending, want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total += 3;
    if (bus.req_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_req_ready: got %b want 0", bus.req_ready);
    end
    if (bus.rsp_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid);
    end
    if ({bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== '0) begin
      bad++; $display("[TB] FAIL reset_rsp_regs: got %h/%b/%b want 0/0/0",
                      bus.rsp_result, bus.rsp_zero, bus.rsp_err);
    end
    rst_n = 1'b1;
    #1;
    total += 2;
    if (bus.req_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL release_req_ready: got %b want 1", bus.req_ready);
    end
    if ({alu_control, alu_src1, alu_src2} !== '0) begin
      bad++; $display("[TB] FAIL idle_alu_drive: got %h/%h/%h want 0/0/0",
                      alu_control, alu_src1, alu_src2);
    end
  endtask

  task automatic test_add();
    applyStimulus(OP_ADD, 32'd5, 32'd7, 1'b1);
    total++;
    if (alu_control !== ALU_ADD || alu_src1 !== 32'd5 || alu_src2 !== 32'd7) begin
      bad++; $display("[TB] FAIL exec_add_drive: got %h/%h/%h want 0/5/7",
                      alu_control, alu_src1, alu_src2);
    end
    wait_drain();
  endtask

  task automatic test_sub();
    applyStimulus(OP_SUB, 32'd9, 32'd9, 1'b1);
    total++;
    if (alu_control !== ALU_SUB) begin
      bad++; $display("[TB] FAIL exec_sub_ctrl: got %h want 1", alu_control);
    end
    wait_drain();
    applyStimulus(OP_SUB, 32'd3, 32'd5, 1'b1);
    wait_drain();
  endtask

  task automatic test_mul();
    applyStimulus(OP_MUL, 32'd6, 32'd7, 1'b1);
    total++;
    if (alu_control !== ALU_ADD || alu_src1 !== 32'd0 || alu_src2 !== 32'd6) begin
      bad++; $display("[TB] FAIL mul_first_drive: got %h/%h/%h want 0/0/6",
                      alu_control, alu_src1, alu_src2);
    end
    wait_drain();
    applyStimulus(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_drain();
    applyStimulus(OP_MUL, 32'h1234_5678, 32'd0, 1'b1);
    wait_drain();
  endtask

  task automatic test_illegal();
    applyStimulus(3'b110, 32'hAAAA_5555, 32'h1111_2222, 1'b1);
    total++;
    if ({alu_control, alu_src1, alu_src2} !== '0) begin
      bad++; $display("[TB] FAIL illegal_alu_drive: got %h/%h/%h want 0/0/0",
                      alu_control, alu_src1, alu_src2);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    int n;
    int t0;
    bus.rsp_ready = 1'b0;
    applyStimulus(OP_ADD, 32'd1, 32'd2, 1'b1);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    bus.req_op    = OP_AND;
    bus.req_a     = 32'hF0F0_F0F0;
    bus.req_b     = 32'h0FF0_0FF0;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd3 || bus.req_ready !== 1'b0) begin
        bad++; $display("[TB] FAIL stall_hold: got valid=%b result=%h ready=%b want 1/3/0",
                        bus.rsp_valid, bus.rsp_result, bus.req_ready);
      end
    end
    bus.rsp_ready = 1'b1;
    t0 = cycle_count;
    applyStimulus(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1);
    total++;
    if (cycle_count - t0 != 2) begin
      bad++; $display("[TB] FAIL pending_accept: got %0d cycles want 2", cycle_count - t0);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [2:0]       ops[6];
    logic [WIDTH-1:0] as[6];
    logic [WIDTH-1:0] bs[6];
    ops = '{OP_ADD, OP_OR, OP_AND, OP_MUL, OP_SUB, OP_MUL};
    as  = '{32'hFFFF_FFFF, 32'h0000_F000, 32'h0, 32'd0, 32'h8000_0000, 32'd12345};
    bs  = '{32'd1, 32'h0F00_0000, 32'hFFFF_FFFF, 32'h0000_0100, 32'd1, 32'd0};
    for (int i = 0; i < 6; i++) applyStimulus(ops[i], as[i], bs[i], 1'b1);
    for (int i = 0; i < 6; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = $urandom;
      rb = $urandom & 32'h0000_FFFF;
      applyStimulus(3'($urandom_range(0, 4)), ra, rb, 1'b1);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid_mul();
    applyStimulus(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total += 3;
    if (bus.rsp_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL abort_rsp_valid: got %b want 0", bus.rsp_valid);
    end
    if (bus.req_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL abort_req_ready: got %b want 0", bus.req_ready);
    end
    if (bus.rsp_result !== '0) begin
      bad++; $display("[TB] FAIL abort_rsp_result: got %h want 0", bus.rsp_result);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL abort_release_ready: got %b want 1", bus.req_ready);
    end
    repeat (40) @(posedge clk);
    #1;
    total++;
    if (in_rsp || bus.rsp_valid) begin
      bad++; $display("[TB] FAIL abort_no_rsp: got rsp_valid=%b want 0", bus.rsp_valid);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    cycle_count = 0;
    in_rsp      = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("[TB] FAIL scoreboard_empty: got %0d left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
